regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback stage and the multi-cycle mult/div unit. Mult/div results are buffered in a small FIFO and drained into idle write slots. A starvation counter forces a drain, stalling the pipeline for that cycle. Publishes a pending-write mask to the hazard unit so the pipeline never reads or overwrites a register with a queued mult/div result.

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/md_wb_fifo.sv | 78 +++++++
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the hard-wired zero register index and the writeback request record.
package regfile_wb_arbiter_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;

   localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] wreg;
      logic [DEF_DATA_W-1:0] wdata;
   } wb_req_t;

endpackage

// File: rtl/md_wb_fifo.sv
// In-order buffer for mult/div writeback results. Exposes per-entry valid and
// destination vectors so the parent can build the pending-write mask.
module md_wb_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic [ADDR_W-1:0]              wreg_i,
   input  logic [DATA_W-1:0]              wdata_i,
   input  logic                           pop_i,
   output logic [ADDR_W-1:0]              head_wreg_o,
   output logic [DATA_W-1:0]              head_wdata_o,
   output logic [$clog2(DEPTH):0]         count_o,
   output logic [DEPTH-1:0]               entry_valid_o,
   output logic [DEPTH-1:0][ADDR_W-1:0]   entry_wreg_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]              count_q, count_d;
   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0][ADDR_W-1:0] wreg_q;
   logic [DEPTH-1:0][DATA_W-1:0] wdata_q;

   // Parent guarantees no push when full and no pop when empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d          = wr_ptr_q + 1'b1;
         valid_d[wr_ptr_q] = 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d          = rd_ptr_q + 1'b1;
         valid_d[rd_ptr_q] = 1'b0;
      end
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         wreg_q   <= '0;
         wdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         if (push_i) begin
            wreg_q[wr_ptr_q]  <= wreg_i;
            wdata_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign head_wreg_o   = wreg_q[rd_ptr_q];
   assign head_wdata_o  = wdata_q[rd_ptr_q];
   assign count_o       = count_q;
   assign entry_valid_o = valid_q;
   assign entry_wreg_o  = wreg_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback stage
// and buffered mult/div results, forcing a drain when the buffer starves.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pipe_valid,
   input  logic [ADDR_W-1:0]           pipe_wreg,
   input  logic [DATA_W-1:0]           pipe_wdata,
   output logic                        pipe_stall,
   input  logic                        md_valid,
   output logic                        md_ready,
   input  logic [ADDR_W-1:0]           md_wreg,
   input  logic [DATA_W-1:0]           md_wdata,
   output logic                        regwrite,
   output logic [ADDR_W-1:0]           wreg,
   output logic [DATA_W-1:0]           wdata,
   output logic [2**ADDR_W-1:0]        pending_mask,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

   logic                               push, pop;
   logic                               fifo_empty, force_drain;
   logic [CntW-1:0]                    fifo_cnt;
   logic [ADDR_W-1:0]                  head_wreg;
   logic [DATA_W-1:0]                  head_wdata;
   logic [FIFO_DEPTH-1:0]              entry_valid;
   logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  entry_wreg;
   logic [StW-1:0]                     starve_q, starve_d;
   wb_req_t                            pipe_req, md_req, sel_req;
   logic                               regwrite_q, regwrite_d;
   logic [ADDR_W-1:0]                  wreg_q, wreg_d;
   logic [DATA_W-1:0]                  wdata_q, wdata_d;

   md_wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i         (clk),
      .rst_ni        (reset),
      .push_i        (push),
      .wreg_i        (md_wreg),
      .wdata_i       (md_wdata),
      .pop_i         (pop),
      .head_wreg_o   (head_wreg),
      .head_wdata_o  (head_wdata),
      .count_o       (fifo_cnt),
      .entry_valid_o (entry_valid),
      .entry_wreg_o  (entry_wreg)
   );

   // Gating with reset keeps md_ready low for as long as reset is held.
   assign md_ready    = reset && (fifo_cnt != CntW'(FIFO_DEPTH));
   assign push        = md_valid && md_ready;
   assign fifo_empty  = (fifo_cnt == '0);
   assign force_drain = !fifo_empty && (starve_q == StW'(STARVE_MAX));
   assign pipe_stall  = force_drain;

   assign pipe_req = '{valid: pipe_valid,
                       wreg:  DEF_ADDR_W'(pipe_wreg),
                       wdata: DEF_DATA_W'(pipe_wdata)};
   assign md_req   = '{valid: !fifo_empty,
                       wreg:  DEF_ADDR_W'(head_wreg),
                       wdata: DEF_DATA_W'(head_wdata)};

   always_comb begin
      pop      = 1'b0;
      sel_req  = '0;
      starve_d = starve_q;
      if (force_drain || (!pipe_valid && !fifo_empty)) begin
         pop     = 1'b1;
         sel_req = md_req;
      end else if (pipe_valid) begin
         sel_req = pipe_req;
      end
      // Reaching the increment means the buffer is non-empty and the pipe won.
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q != StW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_comb begin
      regwrite_d = sel_req.valid && (sel_req.wreg != REG_ZERO);
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      if (regwrite_d) begin
         wreg_d  = ADDR_W'(sel_req.wreg);
         wdata_d = DATA_W'(sel_req.wdata);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q   <= '0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
      end else begin
         starve_q   <= starve_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         if (entry_valid[i]) begin
            pending_mask[entry_wreg[i]] = 1'b1;
         end
      end
      pending_mask[0] = 1'b0;
   end

   assign regwrite   = regwrite_q;
   assign wreg       = wreg_q;
   assign wdata      = wdata_q;
   assign fifo_count = fifo_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for
// backpressure and mid-operation reset, and random traffic against a queue model.
module tb_regfile_wb_arbiter;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              pipe_valid;
   logic [ADDR_W-1:0] pipe_wreg;
   logic [DATA_W-1:0] pipe_wdata;
   logic              pipe_stall;
   logic              md_valid;
   logic              md_ready;
   logic [ADDR_W-1:0] md_wreg;
   logic [DATA_W-1:0] md_wdata;
   logic              regwrite;
   logic [ADDR_W-1:0] wreg;
   logic [DATA_W-1:0] wdata;
   logic [31:0]       pending_mask;
   logic [1:0]        fifo_count;

   int tests  = 0;
   int failed = 0;

   regfile_wb_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pipe_valid   (pipe_valid),
      .pipe_wreg    (pipe_wreg),
      .pipe_wdata   (pipe_wdata),
      .pipe_stall   (pipe_stall),
      .md_valid     (md_valid),
      .md_ready     (md_ready),
      .md_wreg      (md_wreg),
      .md_wdata     (md_wdata),
      .regwrite     (regwrite),
      .wreg         (wreg),
      .wdata        (wdata),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   // Reference model: queued results, starve count, expected registered write.
   logic [ADDR_W-1:0] mq_w[$];
   logic [DATA_W-1:0] mq_d[$];
   int                m_starve;
   logic              m_rw;
   logic [ADDR_W-1:0] m_w;
   logic [DATA_W-1:0] m_d;

   typedef struct {
      logic              pv;
      logic [ADDR_W-1:0] pw;
      logic [DATA_W-1:0] pd;
      logic              mv;
      logic [ADDR_W-1:0] mw;
      logic [DATA_W-1:0] md;
      logic              stall;
      int                cnt;
      logic [31:0]       mask;
      logic              rw;
      logic [ADDR_W-1:0] w;
      logic [DATA_W-1:0] d;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [ADDR_W-1:0] pw, input logic [DATA_W-1:0] pd,
                        input logic mv, input logic [ADDR_W-1:0] mw, input logic [DATA_W-1:0] md);
      pipe_valid = pv;
      pipe_wreg  = pw;
      pipe_wdata = pd;
      md_valid   = mv;
      md_wreg    = mw;
      md_wdata   = md;
   endtask

   task automatic model_clear();
      mq_w.delete();
      mq_d.delete();
      m_starve = 0;
      m_rw     = 1'b0;
   endtask

   // One clock with the current inputs, checked against the model before and after the edge.
   task automatic cycle(output bit pushed, output bit stalled);
      int          n;
      bit          rdy, frc;
      logic [31:0] mask;
      #1;
      n    = mq_w.size();
      rdy  = (n != FIFO_DEPTH);
      frc  = (n != 0) && (m_starve == STARVE_MAX);
      mask = '0;
      foreach (mq_w[i]) mask[mq_w[i]] = 1'b1;
      mask[0] = 1'b0;
      chk("stall", 64'(pipe_stall), 64'(frc));
      chk("md_ready", 64'(md_ready), 64'(rdy));
      chk("fifo_count", 64'(fifo_count), 64'(n));
      chk("pending_mask", 64'(pending_mask), 64'(mask));
      pushed  = md_valid && rdy;
      stalled = frc;
      m_rw    = 1'b0;
      if (frc || (!pipe_valid && n != 0)) begin
         m_w      = mq_w.pop_front();
         m_d      = mq_d.pop_front();
         m_rw     = (m_w != 0);
         m_starve = 0;
      end else begin
         if (pipe_valid) begin
            m_rw = (pipe_wreg != 0);
            m_w  = pipe_wreg;
            m_d  = pipe_wdata;
         end
         if (n == 0) m_starve = 0;
         else if (m_starve < STARVE_MAX) m_starve++;
      end
      if (pushed) begin
         mq_w.push_back(md_wreg);
         mq_d.push_back(md_wdata);
      end
      @(posedge clk);
      #1;
      chk("regwrite", 64'(regwrite), 64'(m_rw));
      if (m_rw) begin
         chk("wreg", 64'(wreg), 64'(m_w));
         chk("wdata", 64'(wdata), 64'(m_d));
      end
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      bit               pushed, stalled;
      logic [ADDR_W-1:0] order[$];
      vecs[0]  = '{1, 3, 'h14,  0, 0, 0,      0, 0, 0,      1, 3, 'h14};
      vecs[1]  = '{0, 0, 0,     1, 8, 'hDEAD, 0, 0, 0,      0, 0, 0};
      vecs[2]  = '{0, 0, 0,     0, 0, 0,      0, 1, 'h100,  1, 8, 'hDEAD};
      vecs[3]  = '{0, 0, 0,     0, 0, 0,      0, 0, 0,      0, 0, 0};
      vecs[4]  = '{1, 1, 'h101, 1, 9, 'h99,   0, 0, 0,      1, 1, 'h101};
      vecs[5]  = '{1, 2, 'h102, 0, 0, 0,      0, 1, 'h200,  1, 2, 'h102};
      vecs[6]  = '{1, 3, 'h103, 0, 0, 0,      0, 1, 'h200,  1, 3, 'h103};
      vecs[7]  = '{1, 4, 'h104, 0, 0, 0,      0, 1, 'h200,  1, 4, 'h104};
      vecs[8]  = '{1, 5, 'h105, 0, 0, 0,      0, 1, 'h200,  1, 5, 'h105};
      vecs[9]  = '{1, 6, 'h106, 0, 0, 0,      1, 1, 'h200,  1, 9, 'h99};
      vecs[10] = '{1, 6, 'h106, 0, 0, 0,      0, 0, 0,      1, 6, 'h106};
      vecs[11] = '{0, 0, 0,     0, 0, 0,      0, 0, 0,      0, 0, 0};
      vecs[12] = '{0, 0, 0,     1, 0, 'h55,   0, 0, 0,      0, 0, 0};
      vecs[13] = '{1, 0, 'h77,  0, 0, 0,      0, 1, 0,      0, 0, 0};
      vecs[14] = '{0, 0, 0,     0, 0, 0,      0, 1, 0,      0, 0, 0};
      vecs[15] = '{0, 0, 0,     0, 0, 0,      0, 0, 0,      0, 0, 0};

      // Reset values while held, then md_ready once released.
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwrite", 64'(regwrite), 64'd0);
      chk("rst_wreg", 64'(wreg), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_mask", 64'(pending_mask), 64'd0);
      chk("rst_stall", 64'(pipe_stall), 64'd0);
      chk("rst_md_ready", 64'(md_ready), 64'd0);
      reset = 1'b1;
      #1;
      chk("rel_md_ready", 64'(md_ready), 64'd1);

      // Directed table: pipe only, idle drain, starvation, zero target.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].pv, vecs[i].pw, vecs[i].pd, vecs[i].mv, vecs[i].mw, vecs[i].md);
         #1;
         chk($sformatf("vec%0d_stall", i), 64'(pipe_stall), 64'(vecs[i].stall));
         chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].cnt));
         chk($sformatf("vec%0d_mask", i), 64'(pending_mask), 64'(vecs[i].mask));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_regwrite", i), 64'(regwrite), 64'(vecs[i].rw));
         if (vecs[i].rw) begin
            chk($sformatf("vec%0d_wreg", i), 64'(wreg), 64'(vecs[i].w));
            chk($sformatf("vec%0d_wdata", i), 64'(wdata), 64'(vecs[i].d));
         end
      end

      // Backpressure: three pushes while the pipe is busy, then drain in order.
      reset_dut();
      drive(1, 10, 'hA0, 1, 4, 'h444);
      cycle(pushed, stalled);
      drive(1, 11, 'hA1, 1, 5, 'h555);
      cycle(pushed, stalled);
      drive(1, 12, 'hA2, 1, 6, 'h666);
      #1;
      chk("full_md_ready", 64'(md_ready), 64'd0);
      chk("full_count", 64'(fifo_count), 64'd2);
      cycle(pushed, stalled);
      chk("full_push_held", 64'(pushed), 64'd0);
      pipe_valid = 1'b0;
      for (int c = 0; c < 12 && order.size() < 3; c++) begin
         if (pushed) md_valid = 1'b0;
         cycle(pushed, stalled);
         if (regwrite && wreg inside {5'd4, 5'd5, 5'd6}) order.push_back(wreg);
      end
      chk("drain_len", 64'(order.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("drain_order%0d", k), 64'(k < order.size() ? order[k] : 5'd0),
             64'(4 + k));
      end

      // Reset while two results are queued.
      reset_dut();
      drive(1, 13, 'hB0, 1, 7, 'h777);
      cycle(pushed, stalled);
      drive(1, 14, 'hB1, 1, 11, 'hBBB);
      cycle(pushed, stalled);
      drive(0, 0, 0, 0, 0, 0);
      chk("pre_rst_count", 64'(fifo_count), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_count", 64'(fifo_count), 64'd0);
      chk("mid_rst_mask", 64'(pending_mask), 64'd0);
      chk("mid_rst_regwrite", 64'(regwrite), 64'd0);
      chk("mid_rst_md_ready", 64'(md_ready), 64'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(pushed, stalled);

      // Random traffic; the pipe holds its request while stalled.
      drive(0, 0, 0, 0, 0, 0);
      stalled = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!stalled) begin
            pipe_valid = ($urandom_range(0, 2) != 0);
            pipe_wreg  = ADDR_W'($urandom_range(0, 31));
            pipe_wdata = $urandom;
         end
         md_valid = $urandom_range(0, 1) == 1;
         md_wreg  = ADDR_W'($urandom_range(0, 31));
         md_wdata = $urandom;
         cycle(pushed, stalled);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
